snn_inference_ctrl: RTL and testbench

//   Sequencer for one SNN inference: clears the LIF/spike-counter network, gates the input

---
 rtl/snn_inference_ctrl.sv | 165 ++++++++++++++++
 tb/tb_snn_inference_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/snn_inference_ctrl.sv
// rtl/snn_inference_ctrl.sv - SNN inference sequencer: clear, stimulate, settle, argmax scan
// Optional feature macro: SNN_TIE_FLAG_EN adds the tie_o output.
module snn_inference_ctrl #(
    parameter int NUM_CLASSES = 10,
    parameter int COUNT_W     = 8,
    parameter int WINDOW_W    = 8,
    parameter int SETTLE_CYC  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [WINDOW_W-1:0] window_len_i,
    output logic                busy_o,
    output logic                net_clr_o,
    output logic                input_en_o,
    output logic [3:0]          count_sel_o,
    input  logic [COUNT_W-1:0]  count_i,
    output logic [3:0]          result_o,
    output logic [COUNT_W-1:0]  result_max_o,
    output logic                result_valid_o,
`ifdef SNN_TIE_FLAG_EN
    output logic                tie_o,
`endif
    output logic                done_o
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W    = (WINDOW_W > SETTLE_W) ? WINDOW_W : SETTLE_W;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       LAST_SEL    = 4'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_SCAN, S_DONE
    } state_t;

    state_t               state_q;
    logic [WINDOW_W-1:0]  window_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [COUNT_W-1:0]   max_q, max_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           count_sel_q;
    logic                 busy_q, net_clr_q, input_en_q, done_q, valid_q;
    logic [3:0]           result_q;
    logic [COUNT_W-1:0]   result_max_q;
    logic                 take;

    // Scan step: class 0 seeds the max; later classes replace it only when strictly larger.
    always_comb begin
        take  = (count_sel_q == 4'd0) || (count_i > max_q);
        max_d = take ? count_i : max_q;
        idx_d = take ? count_sel_q : idx_q;
    end

`ifdef SNN_TIE_FLAG_EN
    logic tie_q, tie_d, tie_out_q;
    always_comb begin
        tie_d = take ? 1'b0 : (tie_q || (count_i == max_q));
    end
    assign tie_o = tie_out_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            window_q     <= '0;
            cnt_q        <= '0;
            max_q        <= '0;
            idx_q        <= '0;
            count_sel_q  <= '0;
            busy_q       <= 1'b0;
            net_clr_q    <= 1'b0;
            input_en_q   <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            result_q     <= '0;
            result_max_q <= '0;
`ifdef SNN_TIE_FLAG_EN
            tie_q        <= 1'b0;
            tie_out_q    <= 1'b0;
`endif
        end else begin
            net_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        window_q  <= window_len_i;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        net_clr_q <= 1'b1;
                        state_q   <= S_CLEAR;
`ifdef SNN_TIE_FLAG_EN
                        tie_out_q <= 1'b0;
`endif
                    end
                end
                S_CLEAR: begin
                    if (window_q != '0) begin
                        state_q    <= S_RUN;
                        input_en_q <= 1'b1;
                        cnt_q      <= CNT_W'(window_q);
                    end else if (SETTLE_CYC != 0) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= SETTLE_LOAD;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_ONE) begin
                        input_en_q <= 1'b0;
                        if (SETTLE_CYC != 0) begin
                            state_q <= S_SETTLE;
                            cnt_q   <= SETTLE_LOAD;
                        end else begin
                            state_q <= S_SCAN;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= S_SCAN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_SCAN: begin
                    max_q <= max_d;
                    idx_q <= idx_d;
`ifdef SNN_TIE_FLAG_EN
                    tie_q <= tie_d;
`endif
                    if (count_sel_q == LAST_SEL) begin
                        state_q      <= S_DONE;
                        count_sel_q  <= 4'd0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        valid_q      <= 1'b1;
                        result_q     <= idx_d;
                        result_max_q <= max_d;
`ifdef SNN_TIE_FLAG_EN
                        tie_out_q    <= tie_d;
`endif
                    end else begin
                        count_sel_q <= count_sel_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign net_clr_o      = net_clr_q;
    assign input_en_o     = input_en_q;
    assign count_sel_o    = count_sel_q;
    assign result_o       = result_q;
    assign result_max_o   = result_max_q;
    assign result_valid_o = valid_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// tb/tb_snn_inference_ctrl.sv - randomized self-checking bench for snn_inference_ctrl
module tb_snn_inference_ctrl;
    localparam int NC = 10;
    localparam int CW = 8;
    localparam int WW = 8;
    localparam int SC = 2;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst_i, start_i;
    logic [WW-1:0] window_len_i;
    logic          busy_o, net_clr_o, input_en_o, result_valid_o, done_o;
    logic [3:0]    count_sel_o, result_o;
    logic [CW-1:0] count_i, result_max_o;
`ifdef SNN_TIE_FLAG_EN
    logic          tie_o;
`endif
    logic [CW-1:0] counts [16];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        int lat; int n_clr; int n_en; int en_first; int busy_low;
        logic v0; logic clr0; logic [3:0] res; logic [CW-1:0] mx; logic vld; logic tie;
    } obs_t;

    snn_inference_ctrl #(.NUM_CLASSES(NC), .COUNT_W(CW), .WINDOW_W(WW), .SETTLE_CYC(SC)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .window_len_i(window_len_i),
        .busy_o(busy_o), .net_clr_o(net_clr_o), .input_en_o(input_en_o),
        .count_sel_o(count_sel_o), .count_i(count_i), .result_o(result_o),
        .result_max_o(result_max_o), .result_valid_o(result_valid_o),
`ifdef SNN_TIE_FLAG_EN
        .tie_o(tie_o),
`endif
        .done_o(done_o)
    );

    always #5 clk = ~clk;
    assign count_i = counts[count_sel_o];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: argmax with lowest index on ties, tie = more than one class at the max.
    function automatic void model(input int w, output int lat, output int idx, output int mx, output logic tie);
        int n;
        lat = 1 + w + SC + NC;
        idx = 0;
        mx = int'(counts[0]);
        for (int i = 1; i < NC; i++) if (int'(counts[i]) > mx) begin mx = int'(counts[i]); idx = i; end
        n = 0;
        for (int i = 0; i < NC; i++) if (int'(counts[i]) == mx) n++;
        tie = (n > 1);
    endfunction

    // Caller raises start_i; observes until done_o, optionally pulsing start_i at cycles pa/pb.
    task automatic run_obs(input int pa, input int pb, output obs_t o);
        o = '0;
        o.lat = -1;
        o.en_first = -1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < BUDGET && o.lat < 0; k++) begin
            if (k == 0) begin o.v0 = result_valid_o; o.clr0 = net_clr_o; end
            if (net_clr_o) o.n_clr++;
            if (input_en_o) begin o.n_en++; if (o.en_first < 0) o.en_first = k; end
            if (done_o) begin
                o.lat = k; o.res = result_o; o.mx = result_max_o; o.vld = result_valid_o;
`ifdef SNN_TIE_FLAG_EN
                o.tie = tie_o;
`endif
            end else begin
                if (!busy_o) o.busy_low++;
                start_i = (k == pa || k == pb);
                if (start_i) window_len_i = WW'($urandom_range(40, 60));
                step();
                start_i = 1'b0;
            end
        end
    endtask

    task automatic quiet(input int n, output int act);
        act = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (done_o || busy_o || net_clr_o || input_en_o) act++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; window_len_i = '0;
        for (int i = 0; i < 16; i++) counts[i] = '0;
        step(); step();
        n_cmp++; if ({busy_o, net_clr_o, input_en_o, done_o, result_valid_o} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy_o, net_clr_o, input_en_o, done_o, result_valid_o}); end
        n_cmp++; if ({count_sel_o, result_o, result_max_o} !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {count_sel_o, result_o, result_max_o}); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        obs_t o; int el, ei, em, act; logic et;
        counts[0] = 3; counts[1] = 9; counts[2] = 4; counts[3] = 9;
        for (int i = 4; i < NC; i++) counts[i] = '0;
        model(5, el, ei, em, et);
        window_len_i = 8'd5; start_i = 1'b1;
        run_obs(-1, -1, o);
        n_cmp++; if (o.lat !== 18 || el !== 18) begin n_bad++; $display("FAIL basic_latency: got %0d want 18", o.lat); end
        n_cmp++; if (o.n_clr !== 1 || o.clr0 !== 1'b1) begin n_bad++; $display("FAIL basic_clr: got %0d cycles want 1", o.n_clr); end
        n_cmp++; if (o.n_en !== 5 || o.en_first !== 1) begin n_bad++; $display("FAIL basic_input_en: got %0d from %0d want 5 from 1", o.n_en, o.en_first); end
        n_cmp++; if (int'(o.res) !== 1 || int'(o.mx) !== 9 || ei !== 1) begin n_bad++; $display("FAIL basic_result: got %0d/%0d want 1/9", o.res, o.mx); end
        n_cmp++; if (o.vld !== 1'b1 || o.busy_low !== 0) begin n_bad++; $display("FAIL basic_valid_busy: got vld %b busy_low %0d want 1 0", o.vld, o.busy_low); end
`ifdef SNN_TIE_FLAG_EN
        n_cmp++; if (o.tie !== 1'b1) begin n_bad++; $display("FAIL basic_tie: got %b want 1", o.tie); end
`endif
        quiet(6, act);
        n_cmp++; if (act !== 0 || result_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_hold: got act %0d vld %b want 0 1", act, result_valid_o); end
    endtask

    task automatic test_mid_run_reset();
        int act;
        window_len_i = 8'd20; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_cmp++; if ({input_en_o, busy_o, result_valid_o, count_sel_o} !== 7'b0) begin n_bad++; $display("FAIL midrst_state: got %b want 0", {input_en_o, busy_o, result_valid_o, count_sel_o}); end
        quiet(40, act);
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", act); end
    endtask

    task automatic test_zero_window();
        obs_t o; int el, ei, em; logic et;
        for (int i = 0; i < NC; i++) counts[i] = CW'($urandom_range(0, 255));
        model(0, el, ei, em, et);
        window_len_i = '0; start_i = 1'b1;
        run_obs(-1, -1, o);
        n_cmp++; if (o.lat !== el || el !== 13) begin n_bad++; $display("FAIL zero_latency: got %0d want 13", o.lat); end
        n_cmp++; if (o.n_en !== 0) begin n_bad++; $display("FAIL zero_input_en: got %0d want 0", o.n_en); end
        n_cmp++; if (int'(o.res) !== ei || int'(o.mx) !== em) begin n_bad++; $display("FAIL zero_result: got %0d/%0d want %0d/%0d", o.res, o.mx, ei, em); end
    endtask

    task automatic test_all_zero();
        obs_t o; int w;
        for (int i = 0; i < NC; i++) counts[i] = '0;
        w = $urandom_range(1, 7);
        window_len_i = WW'(w); start_i = 1'b1;
        run_obs(-1, -1, o);
        n_cmp++; if (o.res !== 4'd0 || o.mx !== '0 || o.vld !== 1'b1) begin n_bad++; $display("FAIL allzero_result: got %0d/%0d/%b want 0/0/1", o.res, o.mx, o.vld); end
`ifdef SNN_TIE_FLAG_EN
        n_cmp++; if (o.tie !== 1'b1) begin n_bad++; $display("FAIL allzero_tie: got %b want 1", o.tie); end
`endif
    endtask

    task automatic test_start_ignored();
        obs_t o; int el, ei, em, act; logic et;
        for (int i = 0; i < NC; i++) counts[i] = CW'($urandom_range(0, 255));
        model(6, el, ei, em, et);
        window_len_i = 8'd6; start_i = 1'b1;
        run_obs(3, 12, o);
        n_cmp++; if (o.lat !== el || o.n_en !== 6 || o.n_clr !== 1) begin n_bad++; $display("FAIL ignore_timing: got lat %0d en %0d clr %0d want %0d 6 1", o.lat, o.n_en, o.n_clr, el); end
        n_cmp++; if (int'(o.res) !== ei || int'(o.mx) !== em) begin n_bad++; $display("FAIL ignore_result: got %0d/%0d want %0d/%0d", o.res, o.mx, ei, em); end
        quiet(12, act);
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL ignore_single_done: got %0d active cycles want 0", act); end
    endtask

    task automatic test_back_to_back();
        obs_t o; int el, ei, em; logic et;
        for (int i = 0; i < NC; i++) counts[i] = CW'($urandom_range(0, 200));
        window_len_i = 8'd3; start_i = 1'b1;
        run_obs(-1, -1, o);
        for (int i = 0; i < NC - 1; i++) counts[i] = CW'($urandom_range(0, 254));
        counts[9] = 8'd255;
        model(4, el, ei, em, et);
        window_len_i = 8'd4; start_i = 1'b1;
        run_obs(-1, -1, o);
        n_cmp++; if (o.v0 !== 1'b0 || o.clr0 !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got vld %b clr %b want 0 1", o.v0, o.clr0); end
        n_cmp++; if (o.res !== 4'd9 || o.mx !== 8'd255 || o.lat !== el) begin n_bad++; $display("FAIL b2b_result: got %0d/%0d lat %0d want 9/255 lat %0d", o.res, o.mx, o.lat, el); end
    endtask

    task automatic test_random();
        obs_t o; int el, ei, em, w, hi; logic et;
        for (int t = 0; t < 10; t++) begin
            hi = (t % 2 == 0) ? 3 : 255;
            for (int i = 0; i < NC; i++) counts[i] = CW'($urandom_range(0, hi));
            w = $urandom_range(0, 15);
            model(w, el, ei, em, et);
            window_len_i = WW'(w); start_i = 1'b1;
            run_obs(-1, -1, o);
            n_cmp++; if (o.lat !== el || o.n_en !== w) begin n_bad++; $display("FAIL rand%0d_timing: got lat %0d en %0d want %0d %0d", t, o.lat, o.n_en, el, w); end
            n_cmp++; if (int'(o.res) !== ei || int'(o.mx) !== em || o.vld !== 1'b1) begin n_bad++; $display("FAIL rand%0d_result: got %0d/%0d/%b want %0d/%0d/1", t, o.res, o.mx, o.vld, ei, em); end
`ifdef SNN_TIE_FLAG_EN
            n_cmp++; if (o.tie !== et) begin n_bad++; $display("FAIL rand%0d_tie: got %b want %b", t, o.tie, et); end
`endif
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_run_reset();
        test_zero_window();
        test_all_zero();
        test_start_ignored();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
